dp_memory: RTL and testbench
============================

# dp_memory

Parametrised dual-port main memory for the DiBU core, successor to the single-port program/data memory. It provides a read-only instruction-fetch port and a read/write data port on one shared bank, with optional registered reads, write-first forwarding, and an optional hardware zero-fill sweep after reset. It sits between the control unit's fetch stage and the load/store datapath.

## Interface
- `WORD_SIZE`, 16, data word width in bits
- `ADDR_SIZE`, 10, address width; depth = 2^ADDR_SIZE words
- `INIT_FILE`, "", binary image loaded with `$readmemb` at time zero; empty string means no load
- `REG_READ`, 1, 1 = registered reads (1-cycle latency); 0 = combinational reads
- `CLEAR_ON_RESET`, 0, 1 = zero-fill the whole bank after every reset
- `clk`  in  1  clock, all state updates on posedge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `i_addr`  in  ADDR_SIZE  fetch-port address
- `i_data`  out  WORD_SIZE  fetch-port read data
- `d_w_en`  in  1  data-port write enable
- `d_addr`  in  ADDR_SIZE  data-port address
- `d_in`  in  WORD_SIZE  data-port write data
- `d_out`  out  WORD_SIZE  data-port read data
- `ready`  out  1  high when the bank accepts writes and read data is valid

## Operation
- States: RESET, CLEAR, READY. An edge with `rst`=1 always forces RESET, from any state including mid-CLEAR.
- RESET → CLEAR (`CLEAR_ON_RESET`=1, clear counter set to 0) or READY (`CLEAR_ON_RESET`=0) on the first edge with `rst`=0.
- CLEAR: each edge writes 0 to `bank[cnt]` and increments `cnt`. The edge that writes address 2^ADDR_SIZE−1 moves to READY. Counter is ADDR_SIZE+1 bits, so there is no wrap.
- `ready` = 1 only in READY. Reset outputs: `ready`=0; `i_data`=`d_out`=0 when `REG_READ`=1.
- Writes: `bank[d_addr] <= d_in` on an edge with `d_w_en`=1 and state READY. Writes in RESET or CLEAR are dropped silently.
- `CLEAR_ON_RESET`=0: reset does not alter bank contents. The `INIT_FILE` image survives reset.
- `REG_READ`=1:
  - On each edge in READY, `i_data <= bank[i_addr]` and `d_out <= bank[d_addr]`.
  - Write-first: if `d_w_en`=1 and a port's address equals `d_addr` on that edge, the port registers `d_in`, not the old word.
  - Outputs hold 0 outside READY.
- `REG_READ`=0: `i_data`/`d_out` are combinational `bank[addr]`. Read-during-write returns the old word until the edge. Outputs are undefined-but-stable while not ready; consumers gate on `ready`.
- Addresses are used at full width with no truncation. Both ports may address the same word in the same cycle.

## Timing
- Registered read latency: address presented before edge N, data valid after edge N.
- Combinational read latency: 0 cycles.
- Write visibility: a write at edge N is seen by either port's read at edge N (registered, forwarded) or after edge N (combinational).
- Clear duration: `ready` rises exactly 2^ADDR_SIZE+1 edges after the last edge with `rst`=1 (1 RESET→CLEAR edge + 2^ADDR_SIZE writes). Default 1025 cycles.
- Without clear: `ready` rises one edge after `rst` deasserts.
- `rst` asserted mid-CLEAR: `ready` stays 0. The sweep restarts from address 0 after deassert, and partially cleared words stay zero.

## Structure
- `WORD_SIZE`/`ADDR_SIZE` defaults and the state encoding (`MEM_RESET`, `MEM_CLEAR`, `MEM_READY`) go in shared `constants.v`. Replace the file-local `word_size`/`addr_size` defines there.
- One sub-module: `mem_clear_seq`. It holds the state register and the clear counter, and drives `ready`, the clear-write enable and the clear address.
- The top level muxes the bank write port between the clear sequencer and the data port, and owns the bank and read registers.

## Test plan
- `CLEAR_ON_RESET`=1, `INIT_FILE` all-ones, `rst` for 2 cycles → `ready`=0 for 1025 cycles then 1; reading addr 0x3FF gives 0x0000.
- `CLEAR_ON_RESET`=0, write 0xBEEF to 0x010 at edge N → `d_out`=0xBEEF after edge N with `d_addr`=0x010 held; after a reset, reading 0x010 still gives 0xBEEF.
- `REG_READ`=1, same-edge write 0x1234 to 0x020 with `i_addr`=`d_addr`=0x020 → `i_data`=`d_out`=0x1234 after that edge.
- `REG_READ`=0, write 0x5555 to 0x030 → `d_out` shows the old word before the edge and 0x5555 after it.
- Assert `rst` at clear cycle 500, release, write 0xAAAA to 0x100 during clear → `ready` rises 1025 edges after release; 0x100 reads 0x0000.
- `ADDR_SIZE`=4, `WORD_SIZE`=8, clear enabled → `ready` after 17 edges; random 200-op read/write traffic on both ports matches the scoreboard.

Source files
------------

// File: rtl/dp_memory_pkg.sv
// Shared defaults and state encoding for the dual-port main memory.
package dp_memory_pkg;
  localparam int WORD_SIZE_DEF = 16;
  localparam int ADDR_SIZE_DEF = 10;

  typedef enum logic [1:0] {
    MEM_RESET = 2'd0,
    MEM_CLEAR = 2'd1,
    MEM_READY = 2'd2
  } mem_state_e;
endpackage

// File: rtl/dp_memory_clear_seq.sv
// Reset/clear/ready sequencer: holds the state register and the zero-fill counter.
module mem_clear_seq
  import dp_memory_pkg::*;
#(
  parameter int ADDR_SIZE      = ADDR_SIZE_DEF,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  output logic                 clr_en,
  output logic [ADDR_SIZE-1:0] clr_addr,
  output mem_state_e           state
);
  // One extra bit so the sweep can never wrap back into the bank.
  localparam logic [ADDR_SIZE:0] LAST = {1'b0, {ADDR_SIZE{1'b1}}};

  logic [ADDR_SIZE:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MEM_RESET;
      cnt    <= '0;
      ready  <= 1'b0;
      clr_en <= 1'b0;
    end else begin
      case (state)
        MEM_RESET: begin
          cnt <= '0;
          if (CLEAR_ON_RESET != 0) begin
            state  <= MEM_CLEAR;
            clr_en <= 1'b1;
          end else begin
            state <= MEM_READY;
            ready <= 1'b1;
          end
        end
        MEM_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= MEM_READY;
            ready  <= 1'b1;
            clr_en <= 1'b0;
          end
        end
        MEM_READY: begin
          ready  <= 1'b1;
          clr_en <= 1'b0;
        end
        default: begin
          state  <= MEM_RESET;
          ready  <= 1'b0;
          clr_en <= 1'b0;
        end
      endcase
    end
  end

  assign clr_addr = cnt[ADDR_SIZE-1:0];
endmodule

// File: rtl/dp_memory.sv
// Dual-port main memory: read-only fetch port and read/write data port on one bank,
// with optional registered write-first reads and a post-reset zero-fill sweep.
module dp_memory
  import dp_memory_pkg::*;
#(
  parameter int    WORD_SIZE      = WORD_SIZE_DEF,
  parameter int    ADDR_SIZE      = ADDR_SIZE_DEF,
  parameter string INIT_FILE      = "",
  parameter int    REG_READ       = 1,
  parameter int    CLEAR_ON_RESET = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_data,
  input  logic                 d_w_en,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_in,
  output logic [WORD_SIZE-1:0] d_out,
  output logic                 ready
);
  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [WORD_SIZE-1:0] bank [DEPTH];

  logic                 clr_en;
  logic [ADDR_SIZE-1:0] clr_addr;
  mem_state_e           state;
  logic                 data_we;
  logic                 bank_we;
  logic [ADDR_SIZE-1:0] bank_addr;
  logic [WORD_SIZE-1:0] bank_data;

  mem_clear_seq #(
    .ADDR_SIZE      (ADDR_SIZE),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .state    (state)
  );

  // Data-port writes outside READY are dropped silently.
  assign data_we   = d_w_en && (state == MEM_READY);
  assign bank_we   = clr_en || data_we;
  assign bank_addr = clr_en ? clr_addr : d_addr;
  assign bank_data = clr_en ? '0 : d_in;

  always_ff @(posedge clk) begin
    if (bank_we) bank[bank_addr] <= bank_data;
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      // Write-first: a port reading the word being written registers the new data.
      always_ff @(posedge clk) begin
        if (rst || state != MEM_READY) begin
          i_data <= '0;
          d_out  <= '0;
        end else begin
          i_data <= (data_we && i_addr == d_addr) ? d_in : bank[i_addr];
          d_out  <= data_we ? d_in : bank[d_addr];
        end
      end
    end else begin : g_comb_read
      assign i_data = bank[i_addr];
      assign d_out  = bank[d_addr];
    end
  endgenerate
endmodule

// File: tb/tb_dp_memory.sv
// Self-checking bench for dp_memory across clear/no-clear and registered/combinational builds.
module tb_dp_memory;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Default geometry, zero-fill on reset, registered reads.
  logic        b_rst = 1'b0, b_we = 1'b0, b_ready;
  logic [9:0]  b_iaddr = '0, b_daddr = '0;
  logic [15:0] b_din = '0, b_idata, b_dout;
  // Default geometry, no clear, registered reads.
  logic        n_rst = 1'b0, n_we = 1'b0, n_ready;
  logic [9:0]  n_iaddr = '0, n_daddr = '0;
  logic [15:0] n_din = '0, n_idata, n_dout;
  // Default geometry, no clear, combinational reads.
  logic        c_rst = 1'b0, c_we = 1'b0, c_ready;
  logic [9:0]  c_iaddr = '0, c_daddr = '0;
  logic [15:0] c_din = '0, c_idata, c_dout;
  // Small geometry, zero-fill on reset, registered reads.
  logic        s_rst = 1'b0, s_we = 1'b0, s_ready;
  logic [3:0]  s_iaddr = '0, s_daddr = '0;
  logic [7:0]  s_din = '0, s_idata, s_dout;

  dp_memory #(.REG_READ(1), .CLEAR_ON_RESET(1)) u_big (
    .clk(clk), .rst(b_rst), .i_addr(b_iaddr), .i_data(b_idata), .d_w_en(b_we),
    .d_addr(b_daddr), .d_in(b_din), .d_out(b_dout), .ready(b_ready));
  dp_memory #(.REG_READ(1), .CLEAR_ON_RESET(0)) u_nc (
    .clk(clk), .rst(n_rst), .i_addr(n_iaddr), .i_data(n_idata), .d_w_en(n_we),
    .d_addr(n_daddr), .d_in(n_din), .d_out(n_dout), .ready(n_ready));
  dp_memory #(.REG_READ(0), .CLEAR_ON_RESET(0)) u_comb (
    .clk(clk), .rst(c_rst), .i_addr(c_iaddr), .i_data(c_idata), .d_w_en(c_we),
    .d_addr(c_daddr), .d_in(c_din), .d_out(c_dout), .ready(c_ready));
  dp_memory #(.WORD_SIZE(8), .ADDR_SIZE(4), .REG_READ(1), .CLEAR_ON_RESET(1)) u_small (
    .clk(clk), .rst(s_rst), .i_addr(s_iaddr), .i_data(s_idata), .d_w_en(s_we),
    .d_addr(s_daddr), .d_in(s_din), .d_out(s_dout), .ready(s_ready));

  logic [15:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b_rst = 1; n_rst = 1; c_rst = 1; s_rst = 1;
    step(); step();
    total_cnt++;
    if ({b_ready, n_ready, c_ready, s_ready} !== 4'b0000)
      $display("FAIL reset_ready: got %b want 0000", {b_ready, n_ready, c_ready, s_ready});
    else pass_cnt++;
    total_cnt++;
    if ({b_idata, b_dout, n_idata, n_dout} !== 64'h0)
      $display("FAIL reset_outputs: got %h want 0", {b_idata, b_dout, n_idata, n_dout});
    else pass_cnt++;
    total_cnt++;
    if ({s_idata, s_dout} !== 16'h0)
      $display("FAIL reset_small_outputs: got %h want 0", {s_idata, s_dout});
    else pass_cnt++;
    n_rst = 0; c_rst = 0;
    step();
    total_cnt++;
    if ({n_ready, c_ready} !== 2'b11)
      $display("FAIL noclear_ready_latency: got %b want 11", {n_ready, c_ready});
    else pass_cnt++;
  endtask

  task automatic test_clear_timing();
    int n = 0;
    b_rst = 1; step(); step();
    b_rst = 0;
    while (!b_ready && n < 2000) begin
      step(); n++;
    end
    total_cnt++;
    if (n !== 1025) $display("FAIL clear_duration: got %0d edges want 1025", n);
    else pass_cnt++;
    b_iaddr = 10'h3FF; b_daddr = 10'h3FF;
    step();
    total_cnt++;
    if ({b_idata, b_dout} !== 32'h0)
      $display("FAIL clear_last_word: got %h want 0", {b_idata, b_dout});
    else pass_cnt++;
  endtask

  task automatic test_mid_clear_reset();
    int n = 0;
    b_rst = 1; step();
    b_rst = 0;
    repeat (500) step();
    b_rst = 1; b_we = 1; b_daddr = 10'h100; b_iaddr = 10'h100; b_din = 16'hAAAA;
    step();
    total_cnt++;
    if (b_ready !== 1'b0) $display("FAIL midclear_ready: got %b want 0", b_ready);
    else pass_cnt++;
    b_rst = 0;
    while (!b_ready && n < 2000) begin
      step(); n++;
    end
    b_we = 0;
    total_cnt++;
    if (n !== 1025) $display("FAIL midclear_duration: got %0d edges want 1025", n);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({b_idata, b_dout} !== 32'h0)
      $display("FAIL midclear_write_dropped: got %h want 0", {b_idata, b_dout});
    else pass_cnt++;
  endtask

  task automatic test_forward();
    b_iaddr = 10'h020; b_daddr = 10'h020; b_din = 16'h1234; b_we = 1;
    step();
    b_we = 0;
    total_cnt++;
    if ({b_idata, b_dout} !== 32'h1234_1234)
      $display("FAIL write_first: got %h want 12341234", {b_idata, b_dout});
    else pass_cnt++;
    b_iaddr = 10'h021;
    step();
    total_cnt++;
    if ({b_idata, b_dout} !== 32'h0000_1234)
      $display("FAIL read_after_write: got %h want 00001234", {b_idata, b_dout});
    else pass_cnt++;
  endtask

  task automatic test_persist();
    n_daddr = 10'h010; n_iaddr = 10'h010; n_din = 16'hBEEF; n_we = 1;
    step();
    n_we = 0;
    total_cnt++;
    if (n_dout !== 16'hBEEF) $display("FAIL persist_write: got %h want beef", n_dout);
    else pass_cnt++;
    n_rst = 1; step();
    total_cnt++;
    if ({n_ready, n_dout} !== 17'h0) $display("FAIL persist_in_reset: got %h want 0", {n_ready, n_dout});
    else pass_cnt++;
    n_rst = 0; n_din = 16'h0; step(); step();
    total_cnt++;
    if ({n_idata, n_dout} !== 32'hBEEF_BEEF)
      $display("FAIL persist_after_reset: got %h want beefbeef", {n_idata, n_dout});
    else pass_cnt++;
  endtask

  task automatic test_comb();
    c_daddr = 10'h030; c_iaddr = 10'h030; c_din = 16'h1111; c_we = 1;
    step();
    c_we = 0;
    #1;
    total_cnt++;
    if (c_dout !== 16'h1111) $display("FAIL comb_first_write: got %h want 1111", c_dout);
    else pass_cnt++;
    c_din = 16'h5555; c_we = 1;
    #1;
    total_cnt++;
    if (c_dout !== 16'h1111) $display("FAIL comb_old_before_edge: got %h want 1111", c_dout);
    else pass_cnt++;
    step();
    c_we = 0;
    total_cnt++;
    if ({c_idata, c_dout} !== 32'h5555_5555)
      $display("FAIL comb_new_after_edge: got %h want 55555555", {c_idata, c_dout});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] model [16];
    logic [15:0] exp_i, exp_d;
    int n = 0;
    s_rst = 1; step();
    s_rst = 0;
    while (!s_ready && n < 100) begin
      step(); n++;
    end
    total_cnt++;
    if (n !== 17) $display("FAIL small_clear_duration: got %0d edges want 17", n);
    else pass_cnt++;
    for (int a = 0; a < 16; a++) model[a] = 8'h00;
    for (int op = 0; op < 200; op++) begin
      s_iaddr = 4'($urandom_range(0, 15));
      s_daddr = (op % 7 == 0) ? s_iaddr : 4'($urandom_range(0, 15));
      s_we    = 1'($urandom_range(0, 1));
      s_din   = 8'($urandom_range(0, 255));
      exp_i = {8'h0, (s_we && s_iaddr == s_daddr) ? s_din : model[s_iaddr]};
      exp_d = {8'h0, s_we ? s_din : model[s_daddr]};
      exp_q.push_back(exp_i);
      exp_q.push_back(exp_d);
      if (s_we) model[s_daddr] = s_din;
      step();
      exp_i = exp_q.pop_front();
      exp_d = exp_q.pop_front();
      total_cnt++;
      if ({8'h0, s_idata} !== exp_i) $display("FAIL rand_i_data op %0d: got %h want %h", op, s_idata, exp_i[7:0]);
      else pass_cnt++;
      total_cnt++;
      if ({8'h0, s_dout} !== exp_d) $display("FAIL rand_d_out op %0d: got %h want %h", op, s_dout, exp_d[7:0]);
      else pass_cnt++;
    end
    s_we = 0;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clear_timing();
    test_mid_clear_reset();
    test_forward();
    test_persist();
    test_comb();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
